mem_bus_arbiter: RTL and testbench

//  Shares the core's single memory/AXI bridge port between IFU instruction fetch and LSU load/store.

---
 rtl/mem_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one memory/bridge port between instruction fetch (IFU)
//               and load/store (LSU). One transaction outstanding at a time,
//               LSU priority with a streak limit so fetch cannot starve, and
//               fetch flush that drops a stale response without aborting the
//               bus beat.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 64,
    parameter int LS_MAX_STREAK = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    // instruction fetch side
    input  logic            i_if_req,
    input  logic [AW-1:0]   i_if_addr,
    input  logic            i_if_flush,
    output logic            o_if_gnt,
    output logic            o_if_rvalid,
    output logic [DW-1:0]   o_if_rdata,
    // load/store side
    input  logic            i_ls_req,
    input  logic            i_ls_wen,
    input  logic [AW-1:0]   i_ls_addr,
    input  logic [DW-1:0]   i_ls_wdata,
    input  logic [DW/8-1:0] i_ls_wstrb,
    output logic            o_ls_gnt,
    output logic            o_ls_rvalid,
    output logic [DW-1:0]   o_ls_rdata,
    // downstream bridge side
    output logic            o_mem_req,
    output logic            o_mem_wen,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wdata,
    output logic [DW/8-1:0] o_mem_wstrb,
    input  logic            i_mem_gnt,
    input  logic            i_mem_rvalid,
    input  logic [DW-1:0]   i_mem_rdata
);

    localparam int         SW           = DW / 8;
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_REQ       = 2'd1;
    localparam logic [1:0] ST_RESP      = 2'd2;
    localparam logic       OWN_IF       = 1'b0;
    localparam logic       OWN_LS       = 1'b1;
    localparam logic [3:0] C_STREAK_MAX = 4'(LS_MAX_STREAK);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic          r_owner;
    logic [3:0]    r_streak;
    logic          r_discard;
    logic          r_wen;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [SW-1:0] r_wstrb;
    logic          w_resp;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: arbitrate in IDLE, wait for bridge accept, wait for response
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (i_if_req || i_ls_req) w_next_state = ST_REQ;
            ST_REQ:  if (i_mem_gnt)            w_next_state = ST_RESP;
            ST_RESP: if (i_mem_rvalid)         w_next_state = ST_IDLE;
            default:                           w_next_state = ST_IDLE;
        endcase
    end

    // Outputs: grants from arbitration, bus payload from registers, responses routed to owner
    always_comb begin
        o_if_gnt    = 1'b0;
        o_ls_gnt    = 1'b0;
        if (r_state == ST_IDLE && !i_rst) begin
            // LSU wins unless the IFU has already waited out a full LSU streak
            if (i_ls_req && !(i_if_req && r_streak == C_STREAK_MAX)) begin
                o_ls_gnt = 1'b1;
            end else if (i_if_req) begin
                o_if_gnt = 1'b1;
            end
        end
        o_mem_req   = (r_state == ST_REQ) && !i_rst;
        o_mem_wen   = r_wen;
        o_mem_addr  = r_addr;
        o_mem_wdata = r_wdata;
        o_mem_wstrb = r_wstrb;
        w_resp      = (r_state == ST_RESP) && i_mem_rvalid && !i_rst;
        // a flush in the response cycle itself also suppresses the fetch data
        o_if_rvalid = w_resp && (r_owner == OWN_IF) && !r_discard && !i_if_flush;
        o_ls_rvalid = w_resp && (r_owner == OWN_LS);
        o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
        o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;
    end

    // Capture the winner's payload and owner on grant
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner <= OWN_IF;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (o_ls_gnt) begin
            r_owner <= OWN_LS;
            r_wen   <= i_ls_wen;
            r_addr  <= i_ls_addr;
            r_wdata <= i_ls_wdata;
            r_wstrb <= i_ls_wstrb;
        end else if (o_if_gnt) begin
            r_owner <= OWN_IF;
            r_wen   <= 1'b0;
            r_addr  <= i_if_addr;
            r_wdata <= '0;
            r_wstrb <= '1;
        end
    end

    // Streak of LSU grants taken while the IFU was waiting
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_streak <= '0;
        end else if (o_if_gnt) begin
            r_streak <= '0;
        end else if (o_ls_gnt && i_if_req) begin
            r_streak <= r_streak + 4'd1;
        end else if (r_state == ST_IDLE && !i_if_req) begin
            r_streak <= '0;
        end
    end

    // Discard flag: a redirect during an IFU transaction drops its response
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_discard <= 1'b0;
        end else if (r_state == ST_IDLE || w_next_state == ST_IDLE) begin
            r_discard <= 1'b0;
        end else if (r_owner == OWN_IF && i_if_flush) begin
            r_discard <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Randomised scoreboard bench for mem_bus_arbiter. Agents raise
//               IFU/LSU requests, a bridge model answers with random waits and
//               injects stray handshakes; a negedge monitor compares grants,
//               bus payload and routed responses against expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int SW   = DW / 8;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_flush, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          ls_req, ls_wen, ls_gnt, ls_rvalid;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rdata;
    logic [SW-1:0] ls_wstrb;
    logic          mem_req, mem_wen, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [SW-1:0] mem_wstrb;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .LS_MAX_STREAK(MAXS)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
        .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_ls_req(ls_req), .i_ls_wen(ls_wen), .i_ls_addr(ls_addr),
        .i_ls_wdata(ls_wdata), .i_ls_wstrb(ls_wstrb),
        .o_ls_gnt(ls_gnt), .o_ls_rvalid(ls_rvalid), .o_ls_rdata(ls_rdata),
        .o_mem_req(mem_req), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
        .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } pay_t;

    typedef struct {
        int            cyc;
        logic          exp_if;
        logic          exp_ls;
        logic          chk_data;
        logic [DW-1:0] data;
    } rsp_t;

    pay_t pq[$];
    rsp_t rq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rst_seen = 1'b0;

    // model state (monitor side)
    int   streak = 0;
    bit   busy = 1'b0;
    bit   req_pending = 1'b0;
    int   req_from = 0;
    bit   if_gnt_seen = 1'b0;
    bit   ls_gnt_seen = 1'b0;

    // stimulus knobs and bridge model state (driver side)
    int   p_if, p_ls, p_flush, max_wait;
    bit   m_phase, m_gnt_given, own_if, own_wen, flushed;
    int   m_wait, m_reqwait;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_seen <= rst;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compare DUT outputs against the transaction-level model
    always @(negedge clk) begin : mon
        logic e_if, e_ls, exp_mr, end_busy;
        rsp_t r;
        pay_t p;
        e_if = 1'b0;
        e_ls = 1'b0;
        end_busy = 1'b0;
        if (rst_seen) begin
            check("rst_if_gnt", if_gnt, 0);
            check("rst_ls_gnt", ls_gnt, 0);
            check("rst_rvalids", {if_rvalid, ls_rvalid}, 0);
            check("rst_mem_req", {mem_req, mem_wen}, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_mem_wstrb", mem_wstrb, 0);
            check("rst_rdata", if_rdata | ls_rdata, 0);
        end
        if (rst) begin
            pq.delete();
            rq.delete();
            streak = 0;
            busy = 1'b0;
            req_pending = 1'b0;
            if_gnt_seen = 1'b0;
            ls_gnt_seen = 1'b0;
        end else begin
            // bus request side
            exp_mr = req_pending && (cyc >= req_from);
            check("mem_req", mem_req, exp_mr);
            if (mem_req && exp_mr) begin
                if (pq.size() == 0) begin
                    check("mem_payload_queue", 1, 0);
                end else begin
                    check("mem_addr", mem_addr, pq[0].addr);
                    check("mem_wen", mem_wen, pq[0].wen);
                    check("mem_wstrb", mem_wstrb, pq[0].wstrb);
                    if (pq[0].wen) check("mem_wdata", mem_wdata, pq[0].wdata);
                    if (mem_gnt) begin
                        void'(pq.pop_front());
                        req_pending = 1'b0;
                    end
                end
            end
            // response side
            if (rq.size() > 0 && rq[0].cyc == cyc) begin
                r = rq.pop_front();
                check("if_rvalid", if_rvalid, r.exp_if);
                check("ls_rvalid", ls_rvalid, r.exp_ls);
                if (r.exp_if) check("if_rdata", if_rdata, r.data);
                if (r.exp_ls && r.chk_data) check("ls_rdata", ls_rdata, r.data);
                end_busy = 1'b1;
            end else begin
                check("if_rvalid_stray", if_rvalid, 0);
                check("ls_rvalid_stray", ls_rvalid, 0);
            end
            // arbitration
            if (!busy && (if_req || ls_req)) begin
                if (ls_req && !(if_req && streak == MAXS)) e_ls = 1'b1;
                else e_if = 1'b1;
            end
            check("if_gnt", if_gnt, e_if);
            check("ls_gnt", ls_gnt, e_ls);
            if (!busy && !if_req) streak = 0;
            if (e_ls && if_req) streak = streak + 1;
            if (e_if) streak = 0;
            if (e_if || e_ls) begin
                if (e_ls) begin
                    p.addr = ls_addr; p.wen = ls_wen; p.wdata = ls_wdata; p.wstrb = ls_wstrb;
                end else begin
                    p.addr = if_addr; p.wen = 1'b0; p.wdata = '0; p.wstrb = '1;
                end
                pq.push_back(p);
                busy = 1'b1;
                req_pending = 1'b1;
                req_from = cyc + 1;
            end
            if (end_busy) busy = 1'b0;
            if (if_gnt) if_gnt_seen = 1'b1;
            if (ls_gnt) ls_gnt_seen = 1'b1;
        end
    end

    // One cycle of agents, flush source and bridge model
    task automatic step();
        rsp_t r;
        if (if_gnt_seen) begin
            if_gnt_seen = 1'b0; if_req = 1'b0; own_if = 1'b1; own_wen = 1'b0; flushed = 1'b0;
        end
        if (ls_gnt_seen) begin
            ls_gnt_seen = 1'b0; ls_req = 1'b0; own_if = 1'b0; own_wen = ls_wen; flushed = 1'b0;
        end
        if (!if_req && $urandom_range(99) < p_if) begin
            if_req = 1'b1;
            if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!ls_req && $urandom_range(99) < p_ls) begin
            ls_req = 1'b1;
            ls_wen = 1'($urandom);
            ls_addr = $urandom;
            ls_wdata = {$urandom, $urandom};
            ls_wstrb = 8'($urandom);
        end
        if_flush = ($urandom_range(99) < p_flush);
        if (if_flush && own_if) flushed = 1'b1;
        if (m_gnt_given) begin
            m_gnt_given = 1'b0;
            m_phase = 1'b1;
            m_wait = $urandom_range(max_wait);
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = {$urandom, $urandom};
        if (m_phase) begin
            if ($urandom_range(3) == 0) mem_gnt = 1'b1;
            if (m_wait == 0) begin
                mem_rvalid = 1'b1;
                r.cyc = cyc; r.exp_if = own_if && !flushed; r.exp_ls = !own_if;
                r.chk_data = !own_wen; r.data = mem_rdata;
                rq.push_back(r);
                m_phase = 1'b0;
                m_reqwait = $urandom_range(max_wait);
            end else begin
                m_wait--;
            end
        end else begin
            if (mem_req) begin
                if (m_reqwait == 0) begin
                    mem_gnt = 1'b1;
                    m_gnt_given = 1'b1;
                end else begin
                    m_reqwait--;
                end
            end else if ($urandom_range(3) == 0) begin
                mem_gnt = 1'b1;
            end
            if ($urandom_range(9) == 0) mem_rvalid = 1'b1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            step();
        end
    endtask

    task automatic reset_driver();
        if_req = 1'b0; ls_req = 1'b0; if_flush = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        m_phase = 1'b0; m_gnt_given = 1'b0; m_wait = 0; m_reqwait = 0;
        own_if = 1'b0; own_wen = 1'b0; flushed = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        if_addr = '0; ls_wen = 1'b0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
        reset_driver();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // zero-wait bridge, light traffic
        p_if = 40; p_ls = 30; p_flush = 5; max_wait = 0;
        run(300);
        // both agents always requesting: exercises the streak limit
        p_if = 100; p_ls = 100; p_flush = 0; max_wait = 0;
        run(200);
        // random bridge waits and frequent redirects
        p_if = 60; p_ls = 60; p_flush = 25; max_wait = 5;
        run(600);

        // reset while a response is outstanding, then a late response
        max_wait = 3; p_flush = 0;
        n = 0;
        do begin
            @(posedge clk); #1;
            step();
            n++;
        end while (!m_phase && n < 50);
        if (!m_phase) check("reach_resp_timeout", 0, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        reset_driver();
        @(posedge clk); #1;
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;

        p_if = 70; p_ls = 50; p_flush = 15; max_wait = 2;
        run(300);

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
